// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a combinational ROM and registers the word
// into the IF/ID slot, handing it to decode over valid/ready with redirect and halt control.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_Clk,
   input  logic        i_reset,
   output logic [31:0] o_rom_addr,
   input  logic [31:0] i_rom_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   input  logic        i_id_ready,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_addr,
   output logic        o_inst_valid,
   output logic        o_misalign,
   output logic        o_halted,
   output logic [31:0] o_fetch_count
);

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;
   logic [31:0] count_q, count_d;

   logic        advance;
   logic        transfer;
   logic [31:0] redirect_tgt;

   assign advance      = !valid_q || i_id_ready;
   assign transfer     = valid_q && i_id_ready;
   assign redirect_tgt = i_redirect_pc & ~32'h3;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      inst_addr_d = inst_addr_q;
      valid_d     = valid_q;
      misalign_d  = 1'b0;
      count_d     = transfer ? count_q + 32'd1 : count_q;

      unique case (state_q)
         StBoot: begin
            // ROM settles for one cycle; an early redirect only moves the PC
            state_d = StRun;
            if (i_redirect) begin
               pc_d = redirect_tgt;
            end
         end
         StRun, StHalt: begin
            if (i_redirect) begin
               pc_d       = redirect_tgt;
               valid_d    = 1'b0;
               inst_d     = NOP_INST;
               misalign_d = |i_redirect_pc[1:0];
               state_d    = i_halt ? StHalt : StRun;
            end else if (i_halt || state_q == StHalt) begin
               // No fetch while halted, and none on the cycle leaving halt
               state_d = i_halt ? StHalt : StRun;
               if (transfer) begin
                  valid_d = 1'b0;
                  inst_d  = NOP_INST;
               end
            end else if (advance) begin
               inst_d      = i_rom_data;
               inst_addr_d = pc_q;
               valid_d     = 1'b1;
               pc_d        = pc_q + 32'd4;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         inst_q      <= NOP_INST;
         inst_addr_q <= 32'h0;
         valid_q     <= 1'b0;
         misalign_q  <= 1'b0;
         count_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         inst_addr_q <= inst_addr_d;
         valid_q     <= valid_d;
         misalign_q  <= misalign_d;
         count_q     <= count_d;
      end
   end

   assign o_rom_addr    = pc_q;
   assign o_inst        = inst_q;
   assign o_inst_addr   = inst_addr_q;
   assign o_inst_valid  = valid_q;
   assign o_misalign    = misalign_q;
   assign o_halted      = (state_q == StHalt) && !valid_q;
   assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: one instance from PC 0 against a writable ROM model,
// a second instance starting near the top of the address space to exercise PC wrap.
module tb_if_fetch_stage;

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        id_ready;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic        misalign;
   logic        halted;
   logic [31:0] fetch_count;

   logic        rst2_n;
   logic [31:0] rom2_addr;
   logic [31:0] rom2_data;
   logic [31:0] inst2;
   logic [31:0] inst2_addr;
   logic        inst2_valid;
   logic        misalign2;
   logic        halted2;
   logic [31:0] fetch2_count;

   logic [31:0] rom [0:63];

   int total = 0;
   int bad   = 0;

   assign rom_data  = rom[rom_addr[7:2]];
   assign rom2_data = rom2_addr ^ 32'h5A5A_0000;

   if_fetch_stage #(
      .RESET_PC(32'h0000_0000),
      .NOP_INST(Nop)
   ) dut (
      .i_Clk        (clk),
      .i_reset      (rst_n),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_data),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .i_halt       (halt),
      .i_id_ready   (id_ready),
      .o_inst       (inst),
      .o_inst_addr  (inst_addr),
      .o_inst_valid (inst_valid),
      .o_misalign   (misalign),
      .o_halted     (halted),
      .o_fetch_count(fetch_count)
   );

   if_fetch_stage #(
      .RESET_PC(32'hFFFF_FFF8),
      .NOP_INST(Nop)
   ) dut2 (
      .i_Clk        (clk),
      .i_reset      (rst2_n),
      .o_rom_addr   (rom2_addr),
      .i_rom_data   (rom2_data),
      .i_redirect   (1'b0),
      .i_redirect_pc(32'h0),
      .i_halt       (1'b0),
      .i_id_ready   (1'b1),
      .o_inst       (inst2),
      .o_inst_addr  (inst2_addr),
      .o_inst_valid (inst2_valid),
      .o_misalign   (misalign2),
      .o_halted     (halted2),
      .o_fetch_count(fetch2_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;
      rst_n       = 1'b0;
      rst2_n      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      halt        = 1'b0;
      id_ready    = 1'b1;

      // Reset values
      tick();
      tick();
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_inst", inst, Nop);
      check("rst_addr", inst_addr, 32'h0);
      check("rst_count", fetch_count, 32'h0);
      check("rst_romaddr", rom_addr, 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_misalign", 32'(misalign), 32'h0);
      rst_n = 1'b1;

      // Boot cycle, then streaming fetch
      tick();
      check("boot_valid", 32'(inst_valid), 32'h0);
      tick();
      check("f0_inst", inst, 32'h1000);
      check("f0_addr", inst_addr, 32'h0);
      check("f0_count", fetch_count, 32'h0);
      tick();
      check("f1_inst", inst, 32'h1001);
      check("f1_addr", inst_addr, 32'h4);
      check("f1_count", fetch_count, 32'h1);
      tick();
      check("f2_inst", inst, 32'h1002);
      check("f2_addr", inst_addr, 32'h8);
      check("f2_count", fetch_count, 32'h2);

      // Back-pressure for three cycles
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_inst", inst, 32'h1002);
         check("stall_addr", inst_addr, 32'h8);
         check("stall_pc", rom_addr, 32'hC);
         check("stall_count", fetch_count, 32'h2);
         check("stall_valid", 32'(inst_valid), 32'h1);
      end
      id_ready = 1'b1;
      tick();
      check("rel_addr", inst_addr, 32'hC);
      check("rel_inst", inst, 32'h1003);
      check("rel_count", fetch_count, 32'h3);
      tick();
      check("rel2_addr", inst_addr, 32'h10);
      check("rel2_count", fetch_count, 32'h4);

      // Redirect while stalled flushes the held word at 0x10
      id_ready    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      check("flush_valid", 32'(inst_valid), 32'h0);
      check("flush_inst", inst, Nop);
      check("flush_count", fetch_count, 32'h4);
      check("flush_pc", rom_addr, 32'h40);
      check("flush_misalign", 32'(misalign), 32'h0);
      redirect = 1'b0;
      id_ready = 1'b1;
      tick();
      check("tgt_addr", inst_addr, 32'h40);
      check("tgt_inst", inst, 32'h1010);
      check("tgt_count", fetch_count, 32'h4);

      // Misaligned redirect: one-cycle pulse, target rounded down
      redirect    = 1'b1;
      redirect_pc = 32'h42;
      tick();
      check("mis_pulse", 32'(misalign), 32'h1);
      check("mis_pc", rom_addr, 32'h40);
      check("mis_valid", 32'(inst_valid), 32'h0);
      check("mis_count", fetch_count, 32'h5);
      redirect = 1'b0;
      tick();
      check("mis_clear", 32'(misalign), 32'h0);
      check("mis_addr", inst_addr, 32'h40);
      check("mis_inst", inst, 32'h1010);
      tick();
      check("mis_next", inst_addr, 32'h44);
      check("mis_cnt2", fetch_count, 32'h6);

      // Halt with a held word at 0x20, rewrite ROM at 0x24 meanwhile
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      tick();
      check("h_count", fetch_count, 32'h7);
      redirect = 1'b0;
      id_ready = 1'b0;
      tick();
      check("h_addr", inst_addr, 32'h20);
      check("h_inst", inst, 32'h1008);
      halt = 1'b1;
      tick();
      check("h_held_valid", 32'(inst_valid), 32'h1);
      check("h_held_halted", 32'(halted), 32'h0);
      check("h_held_pc", rom_addr, 32'h24);
      rom[9]   = 32'hDEAD_BEEF;
      id_ready = 1'b1;
      tick();
      check("h_acc_count", fetch_count, 32'h8);
      check("h_acc_valid", 32'(inst_valid), 32'h0);
      check("h_acc_inst", inst, Nop);
      check("h_halted", 32'(halted), 32'h1);
      check("h_pc", rom_addr, 32'h24);
      halt = 1'b0;
      tick();
      check("h_exit_valid", 32'(inst_valid), 32'h0);
      check("h_exit_halted", 32'(halted), 32'h0);
      tick();
      check("h_res_addr", inst_addr, 32'h24);
      check("h_res_inst", inst, 32'hDEAD_BEEF);
      check("h_res_count", fetch_count, 32'h8);

      // PC wrap on the second instance, then asynchronous reset mid-stream
      rst2_n = 1'b1;
      tick();
      check("w_boot_valid", 32'(inst2_valid), 32'h0);
      tick();
      check("w0_addr", inst2_addr, 32'hFFFF_FFF8);
      check("w0_inst", inst2, 32'hA5A5_FFF8);
      tick();
      check("w1_addr", inst2_addr, 32'hFFFF_FFFC);
      check("w1_pc", rom2_addr, 32'h0);
      tick();
      check("w2_addr", inst2_addr, 32'h0);
      check("w2_inst", inst2, 32'h5A5A_0000);
      check("w2_count", fetch2_count, 32'h2);
      #2;
      rst2_n = 1'b0;
      #1;
      check("ar_valid", 32'(inst2_valid), 32'h0);
      check("ar_inst", inst2, Nop);
      check("ar_addr", inst2_addr, 32'h0);
      check("ar_count", fetch2_count, 32'h0);
      check("ar_pc", rom2_addr, 32'hFFFF_FFF8);
      check("ar_misalign", 32'(misalign2), 32'h0);
      check("ar_halted", 32'(halted2), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
